// File: rtl/uart_tx_arbiter_if.sv
// Frame-requester and UART-side signal bundle for uart_tx_arbiter.
// master drives requests and tx_busy; slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic              tx_busy;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   byte_ack;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  modport master (
    output req, req_data, req_last, tx_busy,
    input  tx_send, tx_data, grant, byte_ack,
    input  frame_done, frame_err, busy
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output tx_send, tx_data, grant, byte_ack,
    output frame_done, frame_err, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding byte frames from NREQ requesters to one UART.
// Bytes of a frame are spaced GAP_CYCLES apart; frames cap at MAX_BYTES.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 100,
  parameter int MAX_BYTES  = 16
) (
  input logic             clk,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [15:0]   GAP_END = 16'(GAP_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant, grant_n;
  logic [PW-1:0]   gidx, gidx_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n;
  logic [15:0]     timer, timer_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last, last_n;
  logic [PW-1:0]   win, cand;
  logic            found;
  logic [7:0]      lane;
  logic            req_g, last_g;
  logic            send, done, err;

  // Pick the first requester after rr_ptr, wrapping around.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr) + 1 + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Select the granted requester's lane, request and last flag.
  always_comb begin
    lane   = '0;
    req_g  = 1'b0;
    last_g = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == PW'(i)) begin
        lane   = bus.req_data[8*i +: 8];
        req_g  = bus.req[i];
        last_g = bus.req_last[i];
      end
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    gidx_n   = gidx;
    rr_ptr_n = rr_ptr;
    timer_n  = timer;
    cnt_n    = cnt;
    last_n   = last;
    send     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = SEND;
          grant_n = ONE << win;
          gidx_n  = win;
          cnt_n   = '0;
          last_n  = 1'b0;
        end
      end
      SEND: begin
        if (!req_g) begin
          err      = 1'b1;
          state_n  = IDLE;
          grant_n  = '0;
          rr_ptr_n = gidx;
        end else if (!bus.tx_busy) begin
          send    = 1'b1;
          last_n  = last_g;
          cnt_n   = cnt + CW'(1);
          timer_n = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (timer >= GAP_END && !bus.tx_busy) begin
          if (last || cnt == CNT_MAX) begin
            done     = last;
            err      = !last;
            state_n  = IDLE;
            grant_n  = '0;
            rr_ptr_n = gidx;
          end else begin
            state_n = SEND;
          end
        end else if (timer != '1) begin
          timer_n = timer + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= PTR_RST;
      timer  <= '0;
      cnt    <= '0;
      last   <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      gidx   <= gidx_n;
      rr_ptr <= rr_ptr_n;
      timer  <= timer_n;
      cnt    <= cnt_n;
      last   <= last_n;
    end
  end

  assign bus.tx_send    = send & ~reset;
  assign bus.tx_data    = bus.tx_send ? lane : 8'h00;
  assign bus.byte_ack   = bus.tx_send ? grant : '0;
  assign bus.frame_done = done & ~reset;
  assign bus.frame_err  = err & ~reset;
  assign bus.grant      = grant;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed frames with
// hand-timed expected events, checked by a negedge monitor.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
    logic [3:0] ack;
    logic [3:0] grant;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic       busy;
  } pr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic done_flag = 1'b0;
  logic [NREQ-1:0] last_ack = '0;

  exp_t sb[$];
  pr_t  pq[$];

  logic [7:0]      mem [NREQ][32];
  int              len [NREQ];
  int              ptr [NREQ];
  logic [NREQ-1:0] last_en;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .GAP_CYCLES(100),
    .MAX_BYTES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic exp_ev(int c, int k, logic [7:0] d,
                        logic [3:0] a, logic [3:0] g);
    exp_t e;
    e.cyc = c; e.kind = k; e.data = d;
    e.ack = a; e.grant = g;
    sb.push_back(e);
  endtask

  task automatic exp_pr(int c, logic [3:0] g, logic b);
    pr_t p;
    p.cyc = c; p.grant = g; p.busy = b;
    pq.push_back(p);
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[8*i +: 8] = mem[i][ptr[i]];
      bus.req_last[i] = last_en[i] && (ptr[i] == len[i] - 1);
    end
  endtask

  // One clock: requesters advance on the ack seen last cycle.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_ack[i]) begin
        if (last_en[i] && ptr[i] == len[i] - 1) ptr[i] = 0;
        else if (ptr[i] < 31) ptr[i]++;
      end
    end
    drive_lanes();
  endtask

  task automatic run_to(int n);
    while (cyc < n) step();
  endtask

  task automatic clr_ptrs();
    for (int i = 0; i < NREQ; i++) ptr[i] = 0;
    drive_lanes();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.tx_busy = 1'b0;
    step();
    step();
    exp_pr(cyc, 4'b0000, 1'b0);
    clr_ptrs();
    step();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output event.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    pr_t  p;
    last_ack = bus.byte_ack;
    if (!bus.tx_send) begin
      checks++;
      if (bus.tx_data !== 8'h00) begin
        failures++;
        $display("FAIL idle_data@%0d: got %02h expected 00",
                 cyc, bus.tx_data);
      end
    end
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      checks++;
      if (p.cyc != cyc || bus.grant !== p.grant
          || bus.busy !== p.busy) begin
        failures++;
        $display("FAIL probe@%0d: got grant=%b busy=%b at %0d expected grant=%b busy=%b",
                 p.cyc, bus.grant, bus.busy, cyc, p.grant, p.busy);
      end
    end
    if (bus.tx_send || bus.frame_done || bus.frame_err
        || (|bus.byte_ack)) begin
      k = 3;
      if (bus.tx_send) k = 0;
      else if (bus.frame_done) k = 1;
      else if (bus.frame_err) k = 2;
      if (int'(bus.tx_send) + int'(bus.frame_done)
          + int'(bus.frame_err) > 1) k = 4;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event@%0d: got kind=%0d data=%02h expected none",
                 cyc, k, bus.tx_data);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.kind != k || e.data !== bus.tx_data
            || e.ack !== bus.byte_ack || e.grant !== bus.grant) begin
          failures++;
          $display("FAIL event: got cyc=%0d kind=%0d data=%02h ack=%b grant=%b expected cyc=%0d kind=%0d data=%02h ack=%b grant=%b",
                   cyc, k, bus.tx_data, bus.byte_ack, bus.grant,
                   e.cyc, e.kind, e.data, e.ack, e.grant);
        end
      end
    end
    if (done_flag) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL missing_events: got %0d left expected 0 (next cyc=%0d)",
                 sb.size(), sb[0].cyc);
      end
      checks++;
      if (pq.size() != 0) begin
        failures++;
        $display("FAIL missing_probes: got %0d left expected 0",
                 pq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int t;
    reset = 1'b1;
    bus.req = '0;
    bus.tx_busy = 1'b0;
    last_en = '0;
    for (int i = 0; i < NREQ; i++) begin
      len[i] = 1;
      ptr[i] = 0;
      for (int j = 0; j < 32; j++) mem[i][j] = 8'h00;
    end
    drive_lanes();

    // Single three-byte frame from requester 0.
    do_reset();
    mem[0][0] = 8'h00; mem[0][1] = 8'h5A; mem[0][2] = 8'hA5;
    len[0] = 3; last_en = 4'b0001;
    clr_ptrs();
    c0 = cyc; t = c0 + 1;
    bus.req = 4'b0001;
    exp_ev(t,       0, 8'h00, 4'b0001, 4'b0001);
    exp_pr(t + 50,  4'b0001, 1'b1);
    exp_ev(t + 100, 0, 8'h5A, 4'b0001, 4'b0001);
    exp_ev(t + 200, 0, 8'hA5, 4'b0001, 4'b0001);
    exp_ev(t + 299, 1, 8'h00, 4'b0000, 4'b0001);
    exp_pr(t + 300, 4'b0000, 1'b0);
    run_to(t + 300);
    bus.req = '0;

    // Round robin over four single-byte frames.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      mem[i][0] = 8'h10 + 8'(i);
      len[i] = 1;
    end
    last_en = 4'b1111;
    clr_ptrs();
    c0 = cyc;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ev(c0 + 1 + 101*k, 0, 8'h10 + 8'(k % 4),
             4'(1 << (k % 4)), 4'(1 << (k % 4)));
      exp_ev(c0 + 100 + 101*k, 1, 8'h00, 4'b0000,
             4'(1 << (k % 4)));
      if (k < 4) exp_pr(c0 + 101 + 101*k, 4'b0000, 1'b0);
    end
    exp_pr(c0 + 505, 4'b0000, 1'b0);
    run_to(c0 + 505);
    bus.req = '0;

    // Backpressure on first byte and at the end of the gap.
    do_reset();
    mem[0][0] = 8'hC3; mem[0][1] = 8'h3C;
    len[0] = 2; last_en = 4'b0001;
    clr_ptrs();
    c0 = cyc; t = c0 + 51;
    bus.req = 4'b0001;
    bus.tx_busy = 1'b1;
    exp_pr(c0 + 30, 4'b0001, 1'b1);
    exp_ev(t,       0, 8'hC3, 4'b0001, 4'b0001);
    exp_pr(t + 105, 4'b0001, 1'b1);
    exp_ev(t + 111, 0, 8'h3C, 4'b0001, 4'b0001);
    exp_ev(t + 210, 1, 8'h00, 4'b0000, 4'b0001);
    exp_pr(t + 211, 4'b0000, 1'b0);
    run_to(t);
    bus.tx_busy = 1'b0;
    run_to(t + 99);
    bus.tx_busy = 1'b1;
    run_to(t + 110);
    bus.tx_busy = 1'b0;
    run_to(t + 211);
    bus.req = '0;

    // Withdrawal in SEND, then requester 3 goes next.
    do_reset();
    mem[3][0] = 8'h77; len[3] = 1;
    last_en = 4'b1000;
    clr_ptrs();
    c0 = cyc;
    bus.req = 4'b1100;
    exp_ev(c0 + 1,   2, 8'h00, 4'b0000, 4'b0100);
    exp_pr(c0 + 2,   4'b0000, 1'b0);
    exp_ev(c0 + 3,   0, 8'h77, 4'b1000, 4'b1000);
    exp_ev(c0 + 102, 1, 8'h00, 4'b0000, 4'b1000);
    exp_pr(c0 + 103, 4'b0000, 1'b0);
    run_to(c0 + 1);
    bus.req = 4'b1000;
    run_to(c0 + 2);
    bus.req = 4'b1011;
    run_to(c0 + 103);
    bus.req = '0;

    // Overrun: no last byte, forced release after 16.
    do_reset();
    for (int j = 0; j < 32; j++) mem[1][j] = 8'h40 + 8'(j);
    len[1] = 32; last_en = 4'b0000;
    clr_ptrs();
    c0 = cyc;
    bus.req = 4'b0010;
    for (int k = 0; k < 16; k++)
      exp_ev(c0 + 1 + 100*k, 0, 8'h40 + 8'(k), 4'b0010, 4'b0010);
    exp_ev(c0 + 1600, 2, 8'h00, 4'b0000, 4'b0010);
    exp_pr(c0 + 1601, 4'b0000, 1'b0);
    run_to(c0 + 1601);
    bus.req = '0;

    // Reset mid-frame after byte 2.
    do_reset();
    mem[0][0] = 8'h81; mem[0][1] = 8'h82; mem[0][2] = 8'h83;
    len[0] = 3; mem[1][0] = 8'h91; len[1] = 1;
    last_en = 4'b0011;
    clr_ptrs();
    c0 = cyc;
    bus.req = 4'b0011;
    exp_ev(c0 + 1,   0, 8'h81, 4'b0001, 4'b0001);
    exp_ev(c0 + 101, 0, 8'h82, 4'b0001, 4'b0001);
    exp_pr(c0 + 151, 4'b0000, 1'b0);
    exp_ev(c0 + 152, 0, 8'h81, 4'b0001, 4'b0001);
    run_to(c0 + 150);
    reset = 1'b1;
    run_to(c0 + 151);
    reset = 1'b0;
    clr_ptrs();
    run_to(c0 + 153);
    reset = 1'b1;
    bus.req = '0;
    step();
    reset = 1'b0;
    step();
    step();
    done_flag = 1'b1;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of frame requesters.
REQ-002 Parameter GAP_CYCLES, 100, exact spacing in clk cycles between consecutive tx_send strobes of one frame when tx_busy=0; SHALL be >= 2.
REQ-003 Parameter MAX_BYTES, 16, byte limit per frame before forced release.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester frame request; held high until release.
REQ-007 req_data  input  8*NREQ  byte lane per requester; lane i = bits [8i+7:8i].
REQ-008 req_last  input  NREQ  lane i byte is the final byte of its frame.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 tx_send  output  1  one-cycle send strobe to UART.
REQ-011 tx_data  output  8  byte to UART; SHALL be 0 when tx_send=0.
REQ-012 grant  output  NREQ  registered one-hot grant; 0 when idle.
REQ-013 byte_ack  output  NREQ  one-cycle pulse to the granted requester when its byte is taken; requester presents the next byte from the following cycle.
REQ-014 frame_done  output  1  one-cycle pulse on normal frame release.
REQ-015 frame_err  output  1  one-cycle pulse on withdrawal or MAX_BYTES release.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 FSM states IDLE, SEND, GAP; 16-bit gap timer; byte counter; latched-last flag; round-robin pointer rr_ptr of clog2(NREQ) bits.
REQ-018 IDLE with any req bit high: winner = first set bit searching upward from (rr_ptr+1) mod NREQ with wrap; next cycle state=SEND, grant=onehot(winner), byte count=0.
REQ-019 IDLE with req=0: stay IDLE; grant=0; all strobes 0.
REQ-020 SEND, req[g]=1, tx_busy=0: same cycle tx_send=1, tx_data=lane g, byte_ack[g]=1; latch req_last[g]; byte count +1; next state GAP with timer=0.
REQ-021 SEND, req[g]=1, tx_busy=1: hold SEND; no strobes.
REQ-022 SEND, req[g]=0: no tx_send/byte_ack; frame_err=1 that cycle; next IDLE, grant=0, rr_ptr=g.
REQ-023 GAP: timer +1 per cycle; exit condition is timer >= GAP_CYCLES-2 and tx_busy=0; otherwise stay.
REQ-024 GAP exit: latched last=1 -> frame_done=1 in exit cycle, next IDLE, grant=0, rr_ptr=g; else byte count==MAX_BYTES -> frame_err=1 in exit cycle, next IDLE, grant=0, rr_ptr=g; else next SEND.
REQ-025 req changes during GAP are ignored; withdrawal is detected only in SEND.
REQ-026 No grant is issued in the release cycle; grant=0 for at least one cycle between frames.
REQ-027 A released requester that still requests has lowest priority at the next arbitration.

Reset
REQ-028 reset high at a rising edge, from any state: state=IDLE, grant=0, rr_ptr=NREQ-1, timer=0, byte count=0, latched last=0.
REQ-029 While reset is high, tx_send, byte_ack, frame_done and frame_err SHALL be forced 0 combinationally.
REQ-030 Reset mid-frame SHALL issue no frame_done/frame_err; requester 0 wins the first arbitration after reset.

Verification
REQ-031 Single frame: req=0001, lane0 bytes 0x00,0x5A,0xA5 (last on third), tx_busy=0, first SEND at cycle T -> tx_send with those bytes at T, T+100, T+200; byte_ack[0] at each; frame_done at T+299; grant=0 from T+300.
REQ-032 Round robin: req=1111 held, all frames 1 byte -> grants 0,1,2,3,0 in order, each separated by >=1 cycle of grant=0.
REQ-033 Backpressure: tx_busy=1 for 50 cycles after entering SEND -> no tx_send; tx_send in the first cycle tx_busy=0; a second byte waits while tx_busy=1 at GAP timer=98.
REQ-034 Withdrawal: grant=0100, req[2] dropped in SEND -> frame_err 1 cycle, no tx_send, grant=0 next cycle, requester 3 has priority next.
REQ-035 Overrun: req_last held 0 -> exactly 16 tx_send, then frame_err and release.
REQ-036 Reset mid-frame after byte 2 with req=0011 -> grant=0 next cycle, no pulses; first grant after reset goes to requester 0.
